banked_register_file: RTL and testbench
=======================================

BANKED_REGISTER_FILE -- requirements
Module: banked_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 4: register count; power of two, at least 2.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 always reads 0 and ignores writes.
REQ-004 SHALL derive localparam AW = clog2(NUM_REGS).
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 rd_addr_a, rd_addr_b  in  AW  read port A/B address.
REQ-008 rd_data_a, rd_data_b  out  DATA_W  read port A/B data.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_addr  in  AW  write address.
REQ-011 wr_data  in  DATA_W  write data.
REQ-012 wr_ready  out  1  write accepted this cycle when high.
REQ-013 save_req  in  1  request copy of the active bank into the shadow bank.
REQ-014 restore_req  in  1  request copy of the shadow bank into the active bank.
REQ-015 busy  out  1  a copy is in progress.
REQ-016 done  out  1  one-cycle pulse after a copy completes.

Function
REQ-017 Reads SHALL be combinational from the active bank; both ports are independent and may use the same address.
REQ-018 A write SHALL commit at the rising edge when wr_en && wr_ready; wr_ready = (state == IDLE).
REQ-019 Bypass: when a write is accepted and rd_addr_x == wr_addr, rd_data_x SHALL equal wr_data in the same cycle.
REQ-020 With ZERO_REG=1, address 0 SHALL read 0 on both ports, including bypass, and writes to it SHALL be discarded.
REQ-021 The FSM SHALL have states IDLE, SAVE and RESTORE; busy = (state != IDLE).
REQ-022 In IDLE, save_req at an edge SHALL enter SAVE with idx=0; restore_req alone SHALL enter RESTORE with idx=0; if both are asserted, save SHALL win.
REQ-023 save_req and restore_req SHALL be ignored while busy.
REQ-024 Each edge in SAVE SHALL copy active[idx] to shadow[idx]; RESTORE SHALL copy shadow[idx] to active[idx]; idx then increments.
REQ-025 The edge that copies idx == NUM_REGS-1 SHALL return the FSM to IDLE and set done for exactly one cycle.
REQ-026 busy SHALL be high for exactly NUM_REGS cycles per copy; done SHALL be high in the first cycle after busy falls.
REQ-027 A write accepted in the same cycle as an accepted save_req SHALL be included in the saved image.
REQ-028 During RESTORE, reads SHALL return the partially restored active bank (entries below idx already restored).
REQ-029 With ZERO_REG=1, RESTORE SHALL NOT make register 0 read nonzero.

Reset
REQ-030 Reset SHALL clear all active and shadow registers to 0 and set state=IDLE, idx=0, busy=0, done=0; wr_ready=1.
REQ-031 Reset asserted mid-copy SHALL abort immediately with no done pulse.

Structure
REQ-032 Package rf_pkg SHALL hold the FSM state enum (IDLE, SAVE, RESTORE).
REQ-033 Sub-module rf_copy_ctrl SHALL contain the FSM and the idx counter and produce busy, done and copy-enable/direction; storage and read muxes remain in the top level.

Verification (DATA_W=8, NUM_REGS=4 unless noted)
REQ-034 Write 0xA5 to r2, then read r2 on A and B -> both 0xA5; the same-cycle bypass read on A also shows 0xA5.
REQ-035 Load r0..r3 = 1,2,3,4; save; overwrite all with 0xFF; restore -> busy high 4 cycles per copy, done pulses once each, r0..r3 read 1,2,3,4.
REQ-036 save_req and restore_req in the same IDLE cycle -> SAVE is taken; save_req asserted during busy is ignored; wr_en during busy -> wr_ready=0 and no register changes.
REQ-037 ZERO_REG=1: write 0x3C to r0 -> reads 0; the bypass read also returns 0.
REQ-038 Assert reset at the second busy cycle of a SAVE -> all registers 0, busy=0, no done pulse; a following write of 0x11 to r1 is accepted.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types for the banked register file.
//   rf_state_t : copy controller state (IDLE, SAVE, RESTORE)
package rf_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } rf_state_t;
endpackage

// File: rtl/rf_copy_ctrl.sv
// Copy sequencer for the banked register file. Walks idx over every register,
// one per clock, in either direction (active->shadow or shadow->active).
// Ports:
//   clk, reset          : clock, async active-high reset
//   save_req            : start active->shadow copy (wins over restore_req)
//   restore_req         : start shadow->active copy
//   busy                : copy in progress (also gates writes in the top)
//   done                : one-cycle pulse after the last register is copied
//   copy_en             : copy idx this cycle
//   copy_restore        : 1 = shadow->active, 0 = active->shadow
//   idx                 : register being copied this cycle
module rf_copy_ctrl
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          save_req,
  input  logic          restore_req,
  output logic          busy,
  output logic          done,
  output logic          copy_en,
  output logic          copy_restore,
  output logic [AW-1:0] idx
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] idx_nxt;
  logic          done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (save_req)         state_nxt = SAVE;
        else if (restore_req) state_nxt = RESTORE;
      end
      SAVE, RESTORE: begin
        // requests are not sampled here: they are ignored while busy
        if (idx == AW'(NUM_REGS - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign copy_en      = busy;
  assign copy_restore = (state == RESTORE);

endmodule

// File: rtl/banked_register_file.sv
// Register file with an active bank and a shadow bank. Two combinational read
// ports with write bypass; one write port that is stalled while a bank copy
// runs. save/restore copy the whole bank one register per clock.
// Ports:
//   clk, reset             : clock, async active-high reset
//   rd_addr_a/b, rd_data_a/b : read ports (active bank, bypassed)
//   wr_en, wr_addr, wr_data  : write request
//   wr_ready               : write accepted this cycle (no copy in progress)
//   save_req, restore_req  : start active->shadow / shadow->active copy
//   busy, done             : copy in progress / one-cycle completion pulse
module banked_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ZERO_REG = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_a,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]           rd_data_a,
  output logic [DATA_W-1:0]           rd_data_b,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  input  logic                        save_req,
  input  logic                        restore_req,
  output logic                        busy,
  output logic                        done
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] active [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];

  logic          copy_en, copy_restore;
  logic [AW-1:0] idx;
  logic          wr_acc;   // write handshake (drives bypass)
  logic          wr_commit; // write that actually lands in storage

  rf_copy_ctrl #(.NUM_REGS(NUM_REGS), .AW(AW)) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .busy         (busy),
    .done         (done),
    .copy_en      (copy_en),
    .copy_restore (copy_restore),
    .idx          (idx)
  );

  assign wr_ready  = !busy;
  assign wr_acc    = wr_en && wr_ready;
  assign wr_commit = wr_acc && !((ZERO_REG != 0) && (wr_addr == '0));

  // Writes and copies never overlap (wr_ready is low while copying), so one
  // source per register per cycle. A write landing on the save-accept edge
  // is therefore in the active bank before the first copy edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        active[r] <= '0;
        shadow[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (copy_en && (idx == AW'(r))) begin
          if (copy_restore) begin
            // register 0 stays zero even if the shadow somehow holds data
            if (!((ZERO_REG != 0) && (r == 0))) active[r] <= shadow[r];
          end else begin
            shadow[r] <= active[r];
          end
        end else if (wr_commit && (wr_addr == AW'(r))) begin
          active[r] <= wr_data;
        end
      end
    end
  end

  // Zero-register mask is applied last so it also overrides the bypass.
  always_comb begin
    rd_data_a = active[rd_addr_a];
    if (wr_acc && (rd_addr_a == wr_addr))            rd_data_a = wr_data;
    if ((ZERO_REG != 0) && (rd_addr_a == '0))        rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = active[rd_addr_b];
    if (wr_acc && (rd_addr_b == wr_addr))            rd_data_b = wr_data;
    if ((ZERO_REG != 0) && (rd_addr_b == '0))        rd_data_b = '0;
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Bench for banked_register_file: two instances (ZERO_REG=0 and ZERO_REG=1)
// share one stimulus stream; a bank-level model predicts every output.
module tb_banked_register_file;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en, save_req, restore_req;

  logic [DW-1:0] rda0, rdb0, rda1, rdb1;
  logic          wrr0, busy0, done0, wrr1, busy1, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  banked_register_file #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda0), .rd_data_b(rdb0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrr0),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy0), .done(done0)
  );

  banked_register_file #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda1), .rd_data_b(rdb1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrr1),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy1), .done(done1)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: two banks per instance, copy as a countdown ----
  int m_act [2][NR];
  int m_sh  [2][NR];
  int left = 0;      // copy edges still to go (0 = idle)
  int pos  = 0;      // next register to copy
  bit m_rest = 0;
  bit m_done = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int z = 0; z < 2; z++)
        for (int r = 0; r < NR; r++) begin
          m_act[z][r] = 0;
          m_sh[z][r]  = 0;
        end
      left = 0; pos = 0; m_done = 0;
    end else begin
      bit dn;
      dn = 0;
      if (left == 0) begin
        if (wr_en)
          for (int z = 0; z < 2; z++)
            if (!(z == 1 && wr_addr == 0)) m_act[z][wr_addr] = int'(wr_data);
        if (save_req)         begin m_rest = 0; pos = 0; left = NR; end
        else if (restore_req) begin m_rest = 1; pos = 0; left = NR; end
      end else begin
        for (int z = 0; z < 2; z++)
          if (m_rest) m_act[z][pos] = m_sh[z][pos];
          else        m_sh[z][pos]  = m_act[z][pos];
        pos++;
        left--;
        if (left == 0) dn = 1;
      end
      m_done = dn;
    end
  end

  function automatic int exp_rd(int z, int a);
    if (z == 1 && a == 0)                        return 0;
    if (wr_en && left == 0 && a == int'(wr_addr)) return int'(wr_data);
    return m_act[z][a];
  endfunction

  always @(negedge clk) begin
    check("rd_a0", rda0, exp_rd(0, int'(rd_addr_a)));
    check("rd_b0", rdb0, exp_rd(0, int'(rd_addr_b)));
    check("rd_a1", rda1, exp_rd(1, int'(rd_addr_a)));
    check("rd_b1", rdb1, exp_rd(1, int'(rd_addr_b)));
    check("busy0", busy0, left != 0);
    check("busy1", busy1, left != 0);
    check("done0", done0, m_done);
    check("done1", done1, m_done);
    check("wrr0",  wrr0,  left == 0);
    check("wrr1",  wrr1,  left == 0);
  end

  // ---------------- directed + random stimulus ----------------------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    wr_en = 0; save_req = 0; restore_req = 0;
  endtask

  task automatic wr(int a, int d);
    cyc(); wr_en = 1; wr_addr = AW'(a); wr_data = DW'(d);
  endtask

  // Called in the first busy cycle with requests already dropped.
  task automatic run_copy(string nm);
    int nb, nd;
    nb = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy0) nb++;
      if (done0) nd++;
      cyc();
    end
    check({nm, "_busy_cycles"}, nb, 4);
    check({nm, "_done_pulses"}, nd, 1);
  endtask

  initial begin
    reset = 1; idle_in();
    rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd", rda0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_wrr", wrr0, 1);
    reset = 0;

    // write 0xA5 to r2 with same-cycle bypass
    wr(2, 'hA5); rd_addr_a = 2; rd_addr_b = 1;
    @(negedge clk);
    check("byp_a", rda0, 'hA5);
    check("byp_b_other", rdb0, 0);
    cyc(); idle_in(); rd_addr_b = 2;
    @(negedge clk);
    check("r2_a", rda0, 'hA5);
    check("r2_b", rdb0, 'hA5);

    // load / save / clobber / restore
    for (int i = 0; i < NR; i++) wr(i, i + 1);
    cyc(); idle_in(); save_req = 1;
    cyc(); save_req = 0;
    run_copy("save");
    for (int i = 0; i < NR; i++) wr(i, 'hFF);
    cyc(); idle_in(); restore_req = 1;
    cyc(); restore_req = 0;
    run_copy("restore");
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      @(negedge clk);
      check("rest_a0", rda0, i + 1);
      check("rest_b1", rdb1, (i == 0) ? 0 : i + 1);
      cyc();
    end

    // save wins over restore; requests and writes ignored while busy
    wr(0, 'h55);
    cyc(); idle_in(); save_req = 1; restore_req = 1;
    cyc(); restore_req = 0; save_req = 1;
    wr_en = 1; wr_addr = 1; wr_data = 'h99; rd_addr_a = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_wrr", wrr0, 0);
      check("busy_nobyp", rda0, 2);
      cyc();
    end
    idle_in();
    @(negedge clk); check("busy4", busy0, 1);
    cyc();
    @(negedge clk); check("both_done", done0, 1); check("both_idle", busy0, 0);
    cyc();
    @(negedge clk); check("no_resave", busy0, 0);
    rd_addr_a = 0; #1; check("save_won", rda0, 'h55);
    rd_addr_a = 1; #1; check("r1_kept", rda0, 2);

    // zero register
    wr(0, 'h3C); rd_addr_a = 0;
    @(negedge clk);
    check("z_byp", rda1, 0);
    check("nz_byp", rda0, 'h3C);
    cyc(); idle_in();
    @(negedge clk);
    check("z_rd", rda1, 0);

    // reset in second busy cycle of a save
    cyc(); save_req = 1;
    cyc(); save_req = 0;
    cyc(); reset = 1;
    @(negedge clk);
    check("abort_busy", busy0, 0);
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = AW'(i); #1;
      check("abort_clr", rda0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(); @(negedge clk); check("abort_nodone", done0, 0);
    end
    reset = 0;
    wr(1, 'h11); rd_addr_a = 1;
    @(negedge clk); check("post_wrr", wrr0, 1);
    cyc(); idle_in();
    @(negedge clk); check("post_r1", rda0, 'h11);

    // random traffic against the model
    repeat (600) begin
      cyc();
      reset       = ($urandom_range(0, 99) == 0);
      wr_en       = $urandom_range(0, 1);
      wr_addr     = AW'($urandom_range(0, NR - 1));
      wr_data     = DW'($urandom);
      rd_addr_a   = AW'($urandom_range(0, NR - 1));
      rd_addr_b   = AW'($urandom_range(0, NR - 1));
      save_req    = ($urandom_range(0, 99) < 8);
      restore_req = ($urandom_range(0, 99) < 8);
    end
    cyc(); reset = 0; idle_in();
    repeat (10) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
